// File: rtl/ahb_sram_slave.sv
// AHB-Lite slave in front of a single-ported on-chip SRAM.
// Address phases are pipelined against data phases. Every OKAY data phase is
// stretched by WAIT_STATES low-ready cycles. Writes use byte lanes. Illegal
// sizes or misaligned transfers get the two-cycle ERROR response.
module ahb_sram_slave #(
    parameter int MEM_BYTES   = 4096,
    parameter int WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP
);

    localparam int AW    = $clog2(MEM_BYTES);
    localparam int WORDS = MEM_BYTES / 4;
    localparam logic [3:0] WS_LOAD = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic            write_q, write_d;
    logic [1:0]      size_q, size_d;
    logic            hreadyout_q, hreadyout_d;
    logic            hresp_q, hresp_d;

    logic            sample;
    logic            accept;
    logic            legal;
    logic            commit;
    logic [3:0]      lane_en;

    logic [31:0]     mem [WORDS];

    // Burst type and high address bits play no part in this slave.
    logic unused_bits;
    assign unused_bits = ^{HBURST, HTRANS[0], HADDR[31:AW]};

    // Byte, halfword and word transfers only; halfwords and words must be naturally aligned.
    function automatic logic legal_xfer(input logic [2:0] size, input logic [1:0] low);
        logic ok;
        ok = 1'b0;
        case (size)
            3'd0:    ok = 1'b1;
            3'd1:    ok = (low[0] == 1'b0);
            3'd2:    ok = (low == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Little-endian lane selection from the latched size and the low offset bits.
    function automatic logic [3:0] lane_enables(input logic [1:0] size, input logic [1:0] low);
        logic [3:0] be;
        case (size)
            2'd0:    be = 4'b0001 << low;
            2'd1:    be = low[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Next-state logic: sample a new address phase whenever this slave is ready to finish.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        write_d = write_q;
        size_d  = size_q;

        case (state_q)
            ST_IDLE: sample = 1'b1;
            ST_DATA: sample = (cnt_q == 4'd0);
            ST_ERR2: sample = 1'b1;
            default: sample = 1'b0;
        endcase

        accept = sample & HSEL & HREADY & HTRANS[1];
        legal  = legal_xfer(HSIZE, HADDR[1:0]);

        case (state_q)
            ST_DATA: if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
            ST_ERR1: state_d = ST_ERR2;
            default: ;
        endcase

        if (sample) begin
            if (accept) begin
                addr_d  = HADDR[AW-1:0];
                write_d = HWRITE;
                size_d  = HSIZE[1:0];
                state_d = legal ? ST_DATA : ST_ERR1;
                cnt_d   = legal ? WS_LOAD : 4'd0;
            end else begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        end

        // Outputs are registered, so they are derived from the state being entered.
        hreadyout_d = !(((state_d == ST_DATA) && (cnt_d != 4'd0)) || (state_d == ST_ERR1));
        hresp_d     = (state_d == ST_ERR1) || (state_d == ST_ERR2);
    end

    // Control state and registered handshake outputs; a reset aborts any transfer in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            addr_q      <= '0;
            write_q     <= 1'b0;
            size_q      <= 2'd0;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            write_q     <= write_d;
            size_q      <= size_d;
            hreadyout_q <= hreadyout_d;
            hresp_q     <= hresp_d;
        end
    end

    assign HREADYOUT = hreadyout_q;
    assign HRESP     = hresp_q;

    // A write lands on the edge that closes its final data cycle; a following read sees it.
    assign commit  = (state_q == ST_DATA) && (cnt_q == 4'd0) && write_q;
    assign lane_en = lane_enables(size_q, addr_q[1:0]);

    // Memory array: byte-lane writes, contents deliberately not reset.
    always_ff @(posedge clk) begin
        if (commit) begin
            for (int n = 0; n < 4; n++) begin
                if (lane_en[n]) mem[addr_q[AW-1:2]][8*n +: 8] <= HWDATA[8*n +: 8];
            end
        end
    end

    // Whole word is returned during read data cycles; zero everywhere else.
    always_comb begin
        HRDATA = 32'd0;
        if ((state_q == ST_DATA) && !write_q) HRDATA = mem[addr_q[AW-1:2]];
    end

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Randomised and directed AHB-Lite master for ahb_sram_slave with a byte-level
// reference memory. The driver predicts each data-phase response when its address
// phase is accepted. A negedge monitor pops and checks that prediction when the
// slave finishes the data phase.
module tb_ahb_sram_slave;

    localparam int MEM_BYTES = 4096;
    localparam int WS        = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;

    assign HREADY = HREADYOUT;

    always #5 clk = ~clk;

    ahb_sram_slave #(
        .MEM_BYTES  (MEM_BYTES),
        .WAIT_STATES(WS)
    ) dut (
        .clk      (clk),
        .reset    (rst),
        .HSEL     (HSEL),
        .HADDR    (HADDR),
        .HTRANS   (HTRANS),
        .HWRITE   (HWRITE),
        .HSIZE    (HSIZE),
        .HBURST   (HBURST),
        .HWDATA   (HWDATA),
        .HREADY   (HREADY),
        .HRDATA   (HRDATA),
        .HREADYOUT(HREADYOUT),
        .HRESP    (HRESP)
    );

    typedef enum int {K_IDLE, K_READ, K_WRITE, K_ERR} kind_t;
    typedef struct {
        kind_t       kind;
        logic [31:0] data;
        logic [31:0] mask;
    } exp_t;

    logic [7:0] mdl   [MEM_BYTES];
    bit         known [MEM_BYTES];
    exp_t       sb [$];
    exp_t       mon_e;
    int         n_checks = 0;
    int         n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, req);
    endtask

    function automatic bit is_legal(input logic [2:0] size, input logic [31:0] addr);
        if (size > 3'd2) return 1'b0;
        if (size == 3'd1 && addr[0] != 1'b0) return 1'b0;
        if (size == 3'd2 && addr[1:0] != 2'b00) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int offset_of(input logic [31:0] addr);
        return int'(addr & 32'(MEM_BYTES - 1));
    endfunction

    task automatic model_write(input logic [2:0] size, input logic [31:0] addr, input logic [31:0] wdata);
        int off;
        int nbytes;
        off    = offset_of(addr);
        nbytes = 1 << size;
        for (int i = 0; i < nbytes; i++) begin
            mdl[off + i]   = wdata[8*((off + i) % 4) +: 8];
            known[off + i] = 1'b1;
        end
    endtask

    // Presents one address phase, waits for it to be accepted, then drives its write data.
    task automatic issue(input bit sel, input logic [1:0] trans, input bit wr, input logic [2:0] size,
                         input logic [31:0] addr, input logic [31:0] wdata, input bit track);
        exp_t e;
        int   waited;
        int   base;
        HSEL   = sel;
        HTRANS = trans;
        HWRITE = wr;
        HSIZE  = size;
        HADDR  = addr;
        HBURST = 3'($urandom);
        waited = 0;
        @(negedge clk);
        while (HREADYOUT !== 1'b1 && waited < 64) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 64) begin
            n_checks++;
            $display("FAIL ready_timeout: HREADYOUT=%b, expected 1 within 64 cycles", HREADYOUT);
        end
        @(posedge clk);
        #1;
        HWDATA = $urandom;
        e.data = 32'd0;
        e.mask = 32'd0;
        if (!(sel && trans[1])) begin
            e.kind = K_IDLE;
        end else if (!is_legal(size, addr)) begin
            e.kind = K_ERR;
        end else if (wr) begin
            e.kind = K_WRITE;
            HWDATA = wdata;
            if (track) model_write(size, addr, wdata);
        end else begin
            e.kind = K_READ;
            base   = offset_of(addr) & ~3;
            for (int i = 0; i < 4; i++) begin
                e.data[8*i +: 8] = mdl[base + i];
                e.mask[8*i +: 8] = known[base + i] ? 8'hFF : 8'h00;
            end
        end
        if (track) sb.push_back(e);
    endtask

    // Monitor: counts low-ready cycles and checks each completed data phase against the scoreboard.
    int lows;
    bit low_resp_any;
    bit low_resp_all;
    always @(negedge clk) begin
        if (rst) begin
            lows         = 0;
            low_resp_any = 1'b0;
            low_resp_all = 1'b1;
        end else if (HREADYOUT !== 1'b1) begin
            lows++;
            if (HRESP === 1'b1) low_resp_any = 1'b1;
            else low_resp_all = 1'b0;
        end else begin
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                case (mon_e.kind)
                    K_READ: begin
                        check("rd_wait_cycles", 32'(lows), 32'(WS));
                        check("rd_wait_resp", 32'(low_resp_any), 32'd0);
                        check("rd_resp", 32'(HRESP), 32'd0);
                        check("rd_data", HRDATA & mon_e.mask, mon_e.data & mon_e.mask);
                    end
                    K_WRITE: begin
                        check("wr_wait_cycles", 32'(lows), 32'(WS));
                        check("wr_resp", 32'(HRESP), 32'd0);
                        check("wr_hrdata_zero", HRDATA, 32'd0);
                    end
                    K_ERR: begin
                        check("err_low_cycles", 32'(lows), 32'd1);
                        check("err_first_resp", 32'(low_resp_all), 32'd1);
                        check("err_second_resp", 32'(HRESP), 32'd1);
                        check("err_hrdata_zero", HRDATA, 32'd0);
                    end
                    default: begin
                        check("idle_wait_cycles", 32'(lows), 32'd0);
                        check("idle_resp", 32'(HRESP), 32'd0);
                        check("idle_hrdata_zero", HRDATA, 32'd0);
                    end
                endcase
            end
            lows         = 0;
            low_resp_any = 1'b0;
            low_resp_all = 1'b1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        rst    = 1'b1;
        HSEL   = 1'b0;
        HADDR  = 32'd0;
        HTRANS = 2'b00;
        HWRITE = 1'b0;
        HSIZE  = 3'd0;
        HBURST = 3'd0;
        HWDATA = 32'd0;
        for (int i = 0; i < MEM_BYTES; i++) begin
            mdl[i]   = 8'h00;
            known[i] = 1'b0;
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset_hreadyout", 32'(HREADYOUT), 32'd1);
        check("reset_hresp", 32'(HRESP), 32'd0);
        check("reset_hrdata", HRDATA, 32'd0);
        rst = 1'b0;

        // Word write then read back.
        issue(1, 2'b10, 1, 3'd2, 32'h10, 32'hDEADBEEF, 1);
        issue(1, 2'b10, 0, 3'd2, 32'h10, 32'h0, 1);
        check("deadbeef_readback", HRDATA, 32'hDEADBEEF);

        // Byte and halfword lane merges.
        issue(1, 2'b10, 1, 3'd0, 32'h13, 32'hAA000000, 1);
        issue(1, 2'b11, 1, 3'd1, 32'h12, 32'h12340000, 1);
        issue(1, 2'b10, 0, 3'd2, 32'h10, 32'h0, 1);
        check("lane_merge_readback", HRDATA, 32'h1234BEEF);

        // Misaligned word write errors and leaves memory untouched.
        issue(1, 2'b10, 1, 3'd2, 32'h00, 32'h01020304, 1);
        issue(1, 2'b10, 1, 3'd2, 32'h02, 32'h11111111, 1);
        issue(1, 2'b10, 0, 3'd2, 32'h00, 32'h0, 1);
        check("err_write_no_effect", HRDATA, 32'h01020304);

        // Illegal size errors; the read accepted during ERR2 completes OKAY.
        issue(1, 2'b10, 0, 3'd3, 32'h20, 32'h0, 1);
        issue(1, 2'b10, 0, 3'd2, 32'h10, 32'h0, 1);

        // Back-to-back write then read of the same word.
        issue(1, 2'b10, 1, 3'd2, 32'h20, 32'h5A5A5A5A, 1);
        issue(1, 2'b10, 0, 3'd2, 32'h20, 32'h0, 1);
        check("raw_back_to_back", HRDATA, 32'h5A5A5A5A);

        // No-transfer slots: IDLE, BUSY, deselected NONSEQ.
        issue(1, 2'b00, 1, 3'd2, 32'h10, 32'hFFFFFFFF, 1);
        issue(1, 2'b01, 1, 3'd2, 32'h10, 32'hFFFFFFFF, 1);
        issue(0, 2'b10, 1, 3'd2, 32'h10, 32'hFFFFFFFF, 1);

        // Offset wraps modulo the memory size.
        issue(1, 2'b10, 0, 3'd2, 32'(MEM_BYTES) + 32'h10, 32'h0, 1);
        issue(1, 2'b10, 1, 3'd0, 32'hFFFF0000 | 32'h21, 32'h0000C300, 1);
        issue(1, 2'b10, 0, 3'd2, 32'h20, 32'h0, 1);

        // Randomised mix over a small window so reads hit written bytes.
        for (int k = 0; k < 300; k++) begin
            logic [2:0]  sz;
            logic [31:0] ad;
            sz = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
            ad = ($urandom & 32'hFFFFF000) | 32'($urandom_range(0, 63));
            issue($urandom_range(0, 7) != 0, 2'($urandom), 1'($urandom), sz, ad, $urandom, 1);
        end

        // Reset in the second wait cycle of a write: aborted, memory keeps the old word.
        issue(1, 2'b10, 1, 3'd2, 32'h10, 32'hCAFEF00D, 0);
        HSEL   = 1'b0;
        HTRANS = 2'b00;
        @(posedge clk);
        #1;
        check("pre_reset_waiting", 32'(HREADYOUT), 32'd0);
        rst = 1'b1;
        #1;
        check("abort_hreadyout", 32'(HREADYOUT), 32'd1);
        check("abort_hresp", 32'(HRESP), 32'd0);
        check("abort_hrdata", HRDATA, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        issue(1, 2'b10, 0, 3'd2, 32'h10, 32'h0, 1);

        // Drain the pipeline and confirm every prediction was consumed.
        issue(1, 2'b00, 0, 3'd0, 32'h0, 32'h0, 1);
        issue(1, 2'b00, 0, 3'd0, 32'h0, 32'h0, 1);
        @(negedge clk);
        @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
